matrix_mac_datapath: RTL and testbench
======================================

Name: matrix_mac_datapath

Overview:
- Datapath responder to the matrix-multiply control FSM: consumes its multiply_matrix / load_matrix / add / done strobes and returns entry_count.
- Holds one 8-entry operand row (A) and column (B), forms the 8 element products, sums them and presents the dot-product result to the host over a valid/ready handshake.
- Sits between the host operand-write port and the FSM; one instance per output element.

Parameters:
- DATA_W, 8, signed operand width (A and B entries).
- N_ENTRIES, 8, entries per dot product; fixed to match the FSM terminal count of 7.
- ACC_W, 2*DATA_W+3, signed accumulator/result width (no overflow for 8 products).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host operand write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_addr  in  3  entry index 0..7
- wr_data  in  DATA_W  signed operand
- multiply_matrix  in  1  from FSM: multiply phase active
- load_matrix  in  1  from FSM: operand buffers locked/being read
- add  in  1  from FSM: accumulate phase (one cycle)
- done  in  1  from FSM: store phase (one cycle)
- entry_count  out  4  to FSM: index of product formed this cycle
- result_data  out  ACC_W  signed dot-product result
- result_valid  out  1  result_data holds an unread result
- result_ready  in  1  host accepts result
- wr_err  out  1  sticky: write attempted while load_matrix high
- ovr_err  out  1  sticky: done arrived while previous result unread

Behaviour:
- One clock; reset is synchronous and active-high. Ports named clock and reset.
- Reset: entry_count=0, result_data=0, result_valid=0, wr_err=0, ovr_err=0, all product registers=0. Operand buffers are not reset.
- Operand write: wr_en && !load_matrix -> buf[wr_sel][wr_addr] <= wr_data next edge. wr_en && load_matrix -> write dropped, wr_err <= 1.
- Entry counter: registered. multiply_matrix=0 -> cleared to 0. multiply_matrix=1 -> prod[cnt] <= A[cnt]*B[cnt] (signed, 2*DATA_W), cnt <= cnt+1.
- Multiply timing: first multiply cycle presents entry_count=0; eighth presents 7; FSM leaves Multiply on that edge. entry_count never exceeds 7 in normal flow. If multiply_matrix stays high past 7, cnt wraps to 0 (3-bit index; entry_count bit 3 always 0).
- add=1: acc <= sign-extended sum of prod[0..7], single cycle. Adder tree is combinational, registered once.
- done=1: result_data <= acc, result_valid <= 1.
  - If result_valid && !result_ready on the same edge: result overwritten, ovr_err <= 1.
  - If result_ready on the same edge: treated as consume-then-load; result_valid stays 1, no error.
- Handshake: result_valid && result_ready -> result_valid <= 0 next edge (unless done coincides). result_data held stable while valid && !ready.
- Latency: done to result_valid is 1 cycle. First multiply cycle to result_valid is 10 cycles (8 multiply + add + done).
- Control strobes are trusted one-hot. With add and done both high, add is ignored and done stores the old acc.
- Reset mid-operation: counter, products, acc and result cleared on the next edge; operand buffers retained.

Optional Feature:
- Macro: MATRIX_MAC_SAT_EN.
- Defined: result is clamped to signed RES_W = 2*DATA_W range on the done transfer (saturate, no wrap); result_data upper bits are a sign extension.
- Undefined: full ACC_W result, no clamping.

Decomposition:
- Shared package matrix_pkg:
  - DATA_W, N_ENTRIES, ACC_W
  - FSM state encoding constants (Idle=0, Multiply=1, Accumulate=2, Store=3)
  - LAST_ENTRY=4'd7
- One natural sub-module: matrix_operand_buf, a 2x8xDATA_W register file with write port and two combinational read ports indexed by cnt.

Test Plan:
- Write A=1..8, B=all 1; pulse multiply_matrix for 8 cycles, then add, then done -> entry_count steps 0..7; result_data=36 with result_valid, 1 cycle after done.
- A=all -128, B=all 127 -> result_data=-130048; with MATRIX_MAC_SAT_EN and RES_W=16 -> result_data=-32768.
- wr_en to A[3] during load_matrix -> A[3] unchanged (re-run gives the same result); wr_err=1 until reset.
- result_ready held 0; run two full sequences -> second result visible and ovr_err=1; result_ready=1 -> result_valid drops next cycle.
- Reset asserted at entry_count=4 -> next cycle entry_count=0, result_valid=0; restarted sequence gives the correct 36.
- done coincident with result_ready while valid -> result_valid stays 1, new value visible, ovr_err=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared widths, FSM state encoding and helpers for the matrix MAC slice.
// Included by the operand buffer, the datapath top and the bench.
package matrix_pkg;

    localparam int DATA_W    = 8;
    localparam int N_ENTRIES = 8;
    localparam int ACC_W     = 2 * DATA_W + 3;
    localparam int RES_W     = 2 * DATA_W;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int IDX_W     = 3;

    localparam logic [3:0] LAST_ENTRY = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MULTIPLY   = 2'd1,
        ST_ACCUMULATE = 2'd2,
        ST_STORE      = 2'd3
    } fsm_state_e;

    localparam logic signed [ACC_W-1:0] RES_MAX =
        ACC_W'((1 << (RES_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

    // Clamp an accumulator value into the signed RES_W range.
    function automatic logic signed [ACC_W-1:0] sat_res(
        input logic signed [ACC_W-1:0] v
    );
        if (v > RES_MAX)
            return RES_MAX;
        else if (v < RES_MIN)
            return RES_MIN;
        else
            return v;
    endfunction

endpackage

// File: rtl/matrix_operand_buf.sv
// 2 x N_ENTRIES operand register file (A row, B column).
// One write port, two combinational read ports sharing one index.
module matrix_operand_buf
    import matrix_pkg::*;
(
    input  logic                     clock,
    input  logic                     we,
    input  logic                     sel,
    input  logic [IDX_W-1:0]         addr,
    input  logic signed [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] a_rd,
    output logic signed [DATA_W-1:0] b_rd
);

    logic signed [DATA_W-1:0] a_mem [N_ENTRIES];
    logic signed [DATA_W-1:0] b_mem [N_ENTRIES];

    // Operand storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (we && !sel)
            a_mem[addr] <= data;
        if (we && sel)
            b_mem[addr] <= data;
    end

    assign a_rd = a_mem[rd_idx];
    assign b_rd = b_mem[rd_idx];

endmodule

// File: rtl/matrix_mac_datapath.sv
// Dot-product datapath driven by the matrix-multiply control FSM.
// Build option MATRIX_MAC_SAT_EN clamps the stored result to 2*DATA_W.
module matrix_mac_datapath
    import matrix_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [IDX_W-1:0]         wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     multiply_matrix,
    input  logic                     load_matrix,
    input  logic                     add,
    input  logic                     done,
    output logic [3:0]               entry_count,
    output logic signed [ACC_W-1:0]  result_data,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     wr_err,
    output logic                     ovr_err
);

    logic [IDX_W-1:0]         cnt;
    logic signed [DATA_W-1:0] a_rd;
    logic signed [DATA_W-1:0] b_rd;
    logic signed [PROD_W-1:0] mul;
    logic signed [PROD_W-1:0] prod [N_ENTRIES];
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  res_next;

    matrix_operand_buf u_buf (
        .clock  (clock),
        .we     (wr_en && !load_matrix),
        .sel    (wr_sel),
        .addr   (wr_addr),
        .data   (wr_data),
        .rd_idx (cnt),
        .a_rd   (a_rd),
        .b_rd   (b_rd)
    );

    assign mul         = a_rd * b_rd;
    assign entry_count = {1'b0, cnt};

    // Adder tree over all products, sign-extended to the accumulator width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_ENTRIES; i++)
            sum = sum + ACC_W'(prod[i]);
    end

    // Value that the store phase transfers into result_data.
    always_comb begin
`ifdef MATRIX_MAC_SAT_EN
        res_next = sat_res(acc);
`else
        res_next = acc;
`endif
    end

    // Entry counter and per-entry product registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < N_ENTRIES; i++)
                prod[i] <= '0;
        end else if (multiply_matrix) begin
            prod[cnt] <= mul;
            cnt       <= cnt + 3'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Accumulate phase; a coincident done wins and add is ignored.
    always_ff @(posedge clock) begin
        if (reset)
            acc <= '0;
        else if (add && !done)
            acc <= sum;
    end

    // Result register, valid/ready handshake and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_data  <= '0;
            result_valid <= 1'b0;
            wr_err       <= 1'b0;
            ovr_err      <= 1'b0;
        end else begin
            if (wr_en && load_matrix)
                wr_err <= 1'b1;
            if (done) begin
                result_data  <= res_next;
                result_valid <= 1'b1;
                if (result_valid && !result_ready)
                    ovr_err <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mac_datapath.sv
// Directed self-checking bench for matrix_mac_datapath.
// Expected values are hand-computed dot products.
module tb_matrix_mac_datapath;
    import matrix_pkg::*;

    logic                     clock;
    logic                     reset;
    logic                     wr_en;
    logic                     wr_sel;
    logic [IDX_W-1:0]         wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     multiply_matrix;
    logic                     load_matrix;
    logic                     add;
    logic                     done;
    logic [3:0]               entry_count;
    logic signed [ACC_W-1:0]  result_data;
    logic                     result_valid;
    logic                     result_ready;
    logic                     wr_err;
    logic                     ovr_err;

    int checks = 0;
    int errors = 0;

    matrix_mac_datapath dut (
        .clock           (clock),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .multiply_matrix (multiply_matrix),
        .load_matrix     (load_matrix),
        .add             (add),
        .done            (done),
        .entry_count     (entry_count),
        .result_data     (result_data),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .wr_err          (wr_err),
        .ovr_err         (ovr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input bit sel, input int addr, input int d);
        logic [31:0] dv;
        logic [31:0] av;
        dv      = d;
        av      = addr;
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = av[IDX_W-1:0];
        wr_data = dv[DATA_W-1:0];
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill(input bit sel, input int base, input int step);
        for (int i = 0; i < N_ENTRIES; i++)
            wr(sel, i, base + step * i);
    endtask

    // Full multiply/add/done pass; ready can be raised on the done cycle.
    task automatic run_seq(input bit chk_cnt, input bit rdy_done);
        load_matrix     = 1'b1;
        multiply_matrix = 1'b1;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (chk_cnt)
                chk("entry_count", {28'b0, entry_count}, i);
            tick();
        end
        multiply_matrix = 1'b0;
        add             = 1'b1;
        tick();
        add          = 1'b0;
        done         = 1'b1;
        result_ready = rdy_done;
        tick();
        done         = 1'b0;
        result_ready = 1'b0;
        load_matrix  = 1'b0;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        int exp_big;
        reset           = 1'b1;
        wr_en           = 1'b0;
        wr_sel          = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
        multiply_matrix = 1'b0;
        load_matrix     = 1'b0;
        add             = 1'b0;
        done            = 1'b0;
        result_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cnt", {28'b0, entry_count}, 0);
        chk("rst_data", result_data, 0);
        chk("rst_valid", {31'b0, result_valid}, 0);
        chk("rst_wr_err", {31'b0, wr_err}, 0);
        chk("rst_ovr_err", {31'b0, ovr_err}, 0);

        // A = 1..8, B = 1 -> 36
        fill(1'b0, 1, 1);
        fill(1'b1, 1, 0);
        run_seq(1'b1, 1'b0);
        chk("t1_valid", {31'b0, result_valid}, 1);
        chk("t1_data", result_data, 36);
        consume();
        chk("t1_consumed", {31'b0, result_valid}, 0);

        // A = -128, B = 127
        fill(1'b0, -128, 0);
        fill(1'b1, 127, 0);
        run_seq(1'b0, 1'b0);
`ifdef MATRIX_MAC_SAT_EN
        exp_big = -32768;
`else
        exp_big = -130048;
`endif
        chk("t2_data", result_data, exp_big);
        chk("t2_ovr_err", {31'b0, ovr_err}, 0);
        consume();

        // Write while locked is dropped and flagged
        fill(1'b0, 1, 1);
        fill(1'b1, 1, 0);
        load_matrix = 1'b1;
        wr(1'b0, 3, 100);
        load_matrix = 1'b0;
        chk("t3_wr_err", {31'b0, wr_err}, 1);
        run_seq(1'b0, 1'b0);
        chk("t3_data", result_data, 36);
        consume();

        // Unread result overwritten
        run_seq(1'b0, 1'b0);
        chk("t4_first", result_data, 36);
        chk("t4_no_ovr", {31'b0, ovr_err}, 0);
        fill(1'b1, 2, 0);
        run_seq(1'b0, 1'b0);
        chk("t4_second", result_data, 72);
        chk("t4_ovr_err", {31'b0, ovr_err}, 1);
        chk("t4_valid", {31'b0, result_valid}, 1);
        consume();
        chk("t4_drop", {31'b0, result_valid}, 0);
        chk("t4_wr_sticky", {31'b0, wr_err}, 1);

        // Reset clears flags; buffers survive
        fill(1'b1, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_wr_clr", {31'b0, wr_err}, 0);
        chk("t5_ovr_clr", {31'b0, ovr_err}, 0);
        run_seq(1'b0, 1'b0);
        chk("t5_pre", result_data, 36);
        load_matrix     = 1'b1;
        multiply_matrix = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        chk("t5_at4", {28'b0, entry_count}, 4);
        reset           = 1'b1;
        multiply_matrix = 1'b0;
        load_matrix     = 1'b0;
        tick();
        reset = 1'b0;
        chk("t5_cnt", {28'b0, entry_count}, 0);
        chk("t5_valid", {31'b0, result_valid}, 0);
        chk("t5_data", result_data, 0);
        run_seq(1'b1, 1'b0);
        chk("t5_rerun", result_data, 36);

        // done with ready while valid: consume-then-load
        fill(1'b0, 2, 0);
        run_seq(1'b0, 1'b1);
        chk("t6_valid", {31'b0, result_valid}, 1);
        chk("t6_data", result_data, 16);
        chk("t6_ovr_err", {31'b0, ovr_err}, 0);
        consume();
        chk("t6_drop", {31'b0, result_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
